// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bundle with valid/ready handshake.
// master = memory stage, slave = wb_stage.
interface wb_stage_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_alu;
   logic [DW-1:0] mem_rdata;
   logic          mem_load;
   logic [2:0]    mem_ltype;

   modport master (
      output mem_valid,
      output mem_we,
      output mem_wa,
      output mem_alu,
      output mem_rdata,
      output mem_load,
      output mem_ltype,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_we,
      input  mem_wa,
      input  mem_alu,
      input  mem_rdata,
      input  mem_load,
      input  mem_ltype,
      output mem_ready
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB stage: load extraction/extension, misalignment trap, one regfile write.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   wb_stage_if.slave     mem,
   input  logic          flush,
   input  logic          wb_stall,
   output logic          reg_we,
   output logic [AW-1:0] reg_wa,
   output logic [DW-1:0] reg_wd,
   output logic          wb_valid,
`ifdef WB_RETIRE_CNT_EN
   output logic [31:0]   retire_cnt,
`endif
   output logic          wb_adel
);

   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   logic          valid_q;
   logic          wr_done_q;
   logic          we_q;
   logic [AW-1:0] wa_q;
   logic [DW-1:0] alu_q;
   logic [DW-1:0] rdata_q;
   logic          load_q;
   logic [2:0]    ltype_q;

   logic          capture;
   logic          retire;
   logic          mis;
   logic [1:0]    off;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] sel_data;

   assign mem.mem_ready = !wb_stall;
   assign capture = mem.mem_valid && !wb_stall && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         wr_done_q <= 1'b0;
         we_q      <= 1'b0;
         wa_q      <= '0;
         alu_q     <= '0;
         rdata_q   <= '0;
         load_q    <= 1'b0;
         ltype_q   <= LT_LW;
      end else if (flush) begin
         valid_q   <= 1'b0;
         wr_done_q <= 1'b0;
      end else if (capture) begin
         valid_q   <= 1'b1;
         wr_done_q <= 1'b0;
         we_q      <= mem.mem_we;
         wa_q      <= mem.mem_wa;
         alu_q     <= mem.mem_alu;
         rdata_q   <= mem.mem_rdata;
         load_q    <= mem.mem_load;
         ltype_q   <= mem.mem_ltype;
      end else if (!wb_stall) begin
         valid_q   <= 1'b0;
         wr_done_q <= 1'b0;
      end else if (valid_q) begin
         // Frozen instruction has had its one chance to write/trap/count.
         wr_done_q <= 1'b1;
      end
   end

   always_comb begin
      off      = alu_q[1:0];
      byte_sel = 8'h00;
      case (off)
         2'd0:    byte_sel = rdata_q[7:0];
         2'd1:    byte_sel = rdata_q[15:8];
         2'd2:    byte_sel = rdata_q[23:16];
         default: byte_sel = rdata_q[31:24];
      endcase
      half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
   end

   always_comb begin
      ld_data = rdata_q;
      mis     = 1'b0;
      case (ltype_q)
         LT_LB: begin
            ld_data = {{24{byte_sel[7]}}, byte_sel};
         end
         LT_LBU: begin
            ld_data = {24'h000000, byte_sel};
         end
         LT_LH: begin
            ld_data = {{16{half_sel[15]}}, half_sel};
            mis     = off[0];
         end
         LT_LHU: begin
            ld_data = {16'h0000, half_sel};
            mis     = off[0];
         end
         default: begin
            // Reserved encodings behave as lw.
            ld_data = rdata_q;
            mis     = |off;
         end
      endcase
      if (!load_q) begin
         mis = 1'b0;
      end
      sel_data = load_q ? ld_data : alu_q;
   end

   assign retire   = valid_q && !wr_done_q && !flush;
   assign reg_we   = retire && we_q && !mis && (wa_q != '0);
   assign reg_wa   = valid_q ? wa_q : '0;
   assign reg_wd   = valid_q ? sel_data : '0;
   assign wb_valid = valid_q;
   assign wb_adel  = retire && mis;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else if (retire) begin
         retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model.
// Counter checks are active when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        wb_stall;
   logic        reg_we;
   logic [4:0]  reg_wa;
   logic [31:0] reg_wd;
   logic        wb_valid;
   logic        wb_adel;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   wb_stage_if #(.DW(32), .AW(5)) mif ();

   wb_stage #(.DW(32), .AW(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem      (mif.slave),
      .flush    (flush),
      .wb_stall (wb_stall),
      .reg_we   (reg_we),
      .reg_wa   (reg_wa),
      .reg_wd   (reg_wd),
      .wb_valid (wb_valid),
`ifdef WB_RETIRE_CNT_EN
      .retire_cnt (retire_cnt),
`endif
      .wb_adel  (wb_adel)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model: the instruction currently in the stage and how
   // many cycles it has been sitting there.
   bit          m_valid = 1'b0;
   int          m_age = 0;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_alu;
   logic [31:0] m_rdata;
   bit          m_load;
   logic [2:0]  m_ltype;
   logic [31:0] m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_data(bit load, logic [2:0] lt,
                                            logic [31:0] a, logic [31:0] d);
      int o;
      logic [31:0] b;
      logic [31:0] h;
      o = int'(a % 4);
      b = (d >> (8 * o)) & 32'hFF;
      h = (d >> (16 * (o / 2))) & 32'hFFFF;
      if (!load) return a;
      case (lt)
         3'd1: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd2: return b;
         3'd3: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd4: return h;
         default: return d;
      endcase
   endfunction

   function automatic bit ref_mis(bit load, logic [2:0] lt, logic [31:0] a);
      int o;
      o = int'(a % 4);
      if (!load) return 1'b0;
      if (lt == 3'd1 || lt == 3'd2) return 1'b0;
      if (lt == 3'd3 || lt == 3'd4) return (o % 2) != 0;
      return o != 0;
   endfunction

   task automatic tick();
      bit          retire;
      bit          mis;
      logic [31:0] d;
      #1;
      retire = m_valid && (m_age == 0) && !flush;
      mis    = m_valid && ref_mis(m_load, m_ltype, m_alu);
      d      = ref_data(m_load, m_ltype, m_alu, m_rdata);
      if (chk_en) begin
         chk("mem_ready", 32'(mif.mem_ready), 32'(!wb_stall));
         chk("wb_valid", 32'(wb_valid), 32'(m_valid));
         chk("reg_we", 32'(reg_we),
             32'(retire && m_we && !mis && m_wa != 0));
         chk("reg_wa", 32'(reg_wa), m_valid ? 32'(m_wa) : 32'd0);
         chk("reg_wd", reg_wd, m_valid ? d : 32'd0);
         chk("wb_adel", 32'(wb_adel), 32'(retire && mis));
`ifdef WB_RETIRE_CNT_EN
         chk("retire_cnt", retire_cnt, m_cnt);
`endif
      end
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_cnt   = 0;
      end else begin
         if (retire) m_cnt = m_cnt + 1;
         if (flush) begin
            m_valid = 1'b0;
         end else if (!wb_stall) begin
            m_valid = mif.mem_valid;
            m_age   = 0;
            m_we    = mif.mem_we;
            m_wa    = mif.mem_wa;
            m_alu   = mif.mem_alu;
            m_rdata = mif.mem_rdata;
            m_load  = mif.mem_load;
            m_ltype = mif.mem_ltype;
         end else begin
            m_age++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_in();
      rst           = 1'b0;
      flush         = 1'b0;
      wb_stall      = 1'b0;
      mif.mem_valid = 1'b0;
   endtask

   task automatic offer(input bit we, input logic [4:0] wa,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input bit load, input logic [2:0] lt);
      mif.mem_valid = 1'b1;
      mif.mem_we    = we;
      mif.mem_wa    = wa;
      mif.mem_alu   = alu;
      mif.mem_rdata = rd;
      mif.mem_load  = load;
      mif.mem_ltype = lt;
   endtask

   // Capture one load, then check the extended write data in the next cycle.
   task automatic load_case(input string tag, input logic [2:0] lt,
                            input logic [31:0] alu, input logic [31:0] exp);
      idle_in();
      offer(1'b1, 5'd3, alu, 32'h80FF7F01, 1'b1, lt);
      tick();
      idle_in();
      #1;
      chk({tag, "_we"}, 32'(reg_we), 32'd1);
      chk({tag, "_wd"}, reg_wd, exp);
      tick();
      chk({tag, "_we_gone"}, 32'(reg_we), 32'd0);
   endtask

   task automatic misaligned_case(input string tag, input logic [2:0] lt,
                                  input logic [31:0] alu);
      idle_in();
      offer(1'b1, 5'd4, alu, 32'hCAFEF00D, 1'b1, lt);
      tick();
      idle_in();
      wb_stall = 1'b1;
      #1;
      chk({tag, "_adel1"}, 32'(wb_adel), 32'd1);
      chk({tag, "_we1"}, 32'(reg_we), 32'd0);
      tick();
      chk({tag, "_adel2"}, 32'(wb_adel), 32'd0);
      chk({tag, "_we2"}, 32'(reg_we), 32'd0);
      tick();
      idle_in();
      tick();
   endtask

   int          pulses;
   logic [31:0] cnt0;

   initial begin
      mif.mem_we    = 1'b0;
      mif.mem_wa    = '0;
      mif.mem_alu   = '0;
      mif.mem_rdata = '0;
      mif.mem_load  = 1'b0;
      mif.mem_ltype = '0;
      idle_in();
      @(negedge clk);

      // Reset for two cycles while an instruction is offered.
      rst = 1'b1;
      offer(1'b1, 5'd9, 32'h55, 32'h0, 1'b0, 3'd0);
      tick();
      chk_en = 1'b1;
      tick();
      idle_in();
      #1;
      chk("rst_we", 32'(reg_we), 32'd0);
      chk("rst_valid", 32'(wb_valid), 32'd0);
      chk("rst_ready", 32'(mif.mem_ready), 32'd1);
`ifdef WB_RETIRE_CNT_EN
      chk("rst_cnt", retire_cnt, 32'd0);
`endif

      load_case("lb3", 3'd1, 32'h2003, 32'hFFFFFF80);
      load_case("lbu3", 3'd2, 32'h2003, 32'h00000080);
      load_case("lh2", 3'd3, 32'h2002, 32'hFFFF80FF);
      load_case("lhu0", 3'd4, 32'h2000, 32'h00007F01);

      misaligned_case("lw_mis", 3'd0, 32'h1002);
      misaligned_case("lh_mis", 3'd3, 32'h1003);

      // Stall: one write across a four-cycle freeze.
      idle_in();
      offer(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 3'd0);
      tick();
      offer(1'b1, 5'd6, 32'h5678, 32'h0, 1'b0, 3'd0);
      wb_stall = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (reg_we) pulses++;
         chk("stall_ready", 32'(mif.mem_ready), 32'd0);
         chk("stall_wd", reg_wd, 32'h00001234);
         tick();
      end
      chk("stall_pulses", 32'(pulses), 32'd1);
      wb_stall = 1'b0;
      tick();
      idle_in();
      #1;
      chk("stall_next_wa", 32'(reg_wa), 32'd6);
      chk("stall_next_we", 32'(reg_we), 32'd1);
      tick();

      // Flush kills both the held and the offered instruction.
      offer(1'b1, 5'd7, 32'hAAAA, 32'h0, 1'b0, 3'd0);
      tick();
      offer(1'b1, 5'd8, 32'hBBBB, 32'h0, 1'b0, 3'd0);
      flush = 1'b1;
      #1;
      chk("flush_we", 32'(reg_we), 32'd0);
      tick();
      idle_in();
      #1;
      chk("flush_valid", 32'(wb_valid), 32'd0);
      chk("flush_we2", 32'(reg_we), 32'd0);

      // Write to $0 retires without writing.
`ifdef WB_RETIRE_CNT_EN
      cnt0 = retire_cnt;
`else
      cnt0 = 0;
`endif
      offer(1'b1, 5'd0, 32'h77, 32'h0, 1'b0, 3'd0);
      tick();
      idle_in();
      #1;
      chk("r0_we", 32'(reg_we), 32'd0);
      chk("r0_valid", 32'(wb_valid), 32'd1);
      tick();
`ifdef WB_RETIRE_CNT_EN
      chk("r0_cnt", retire_cnt, cnt0 + 32'd1);

      // Counter wrap from all-ones.
      force dut.retire_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt_q;
      m_cnt = 32'hFFFFFFFF;
      offer(1'b1, 5'd2, 32'h10, 32'h0, 1'b0, 3'd0);
      tick();
      idle_in();
      tick();
      chk("cnt_wrap", retire_cnt, 32'd0);
`endif

      // Randomized traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 99) < 2);
         flush    = ($urandom_range(0, 99) < 8);
         wb_stall = ($urandom_range(0, 99) < 25);
         offer($urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom,
               $urandom_range(0, 99) < 60,
               3'($urandom_range(0, 7)));
         mif.mem_valid = ($urandom_range(0, 99) < 70);
         tick();
      end

      idle_in();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline stage of the MIPS core; directly upstream of the register file write port.
- Latches the retiring instruction from the memory stage and performs load-data byte/halfword extraction with sign/zero extension.
- Produces exactly one register-file write per retired instruction.
- Flags misaligned loads and suppresses their writes.

Parameters:
- DW, 32, data width; only 32 is supported.
- AW, 5, register address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  stage can accept; equals !wb_stall
- mem_we  in  1  instruction writes a GPR
- mem_wa  in  5  destination register
- mem_alu  in  32  ALU result; for loads, the effective address
- mem_rdata  in  32  data-memory word at {mem_alu[31:2],2'b00}
- mem_load  in  1  instruction is a load
- mem_ltype  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others reserved
- flush  in  1  kill the held and the incoming instruction
- wb_stall  in  1  hazard-unit freeze
- reg_we  out  1  regfile write enable
- reg_wa  out  5  regfile write address
- reg_wd  out  32  regfile write data
- wb_valid  out  1  stage holds a live instruction
- wb_adel  out  1  one-cycle pulse: misaligned load retired

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, on a rising clk edge with rst=1:
  - Clears valid, wr_done, all held fields and the retire counter.
  - Outputs go to: reg_we=0, reg_wa=0, reg_wd=0, wb_valid=0, wb_adel=0, mem_ready=1 on the following cycle.
  - rst overrides flush, stall and capture.
- Capture, at posedge when mem_valid & mem_ready & !flush:
  - Latch we, wa, alu, rdata, load, ltype, valid=1, wr_done=0.
- Idle: if mem_valid=0 with ready=1 and no flush, valid becomes 0 at the edge (bubble).
- Stall (wb_stall=1):
  - mem_ready=0 and the held contents are frozen.
  - wr_done prevents a second write.
- Flush: at the edge valid=0 and wr_done=0, regardless of stall; an instruction offered in the same cycle is discarded.
- Data select, combinational from held fields, offset o = alu[1:0]:
  - lw: rdata.
  - lb/lbu: byte o (o=0 -> rdata[7:0], little-endian), sign- or zero-extended.
  - lh/lhu: o[1]=0 -> rdata[15:0], o[1]=1 -> rdata[31:16], sign- or zero-extended.
  - non-load: alu.
  - reserved ltype: treated as lw.
- Misalignment: lw with o!=0, or lh/lhu with o[0]=1, sets mis=1.
- Write, combinational: reg_we = valid & we & !wr_done & !mis & (wa!=0) & !flush.
  - reg_wa = wa and reg_wd = selected data whenever valid; both are 0 when invalid.
- wr_done: set at the edge after reg_we=1 if the stage is still held (stalled); cleared on capture.
  - The write therefore occurs in the first cycle the instruction is held: latency 1 cycle from capture.
- wb_adel: 1 for exactly one cycle, the first held cycle of a misaligned load (gated by the same wr_done logic); 0 otherwise.
- Writes to $0 are never issued: reg_we=0, but the instruction still retires.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments once per retired instruction, i.e. in the first held cycle of each valid instruction (including $0 writes, non-writing instructions and misaligned loads).
  - Not incremented on flushed instructions.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with mem_valid=1 -> reg_we=0, wb_valid=0, mem_ready=1, retire_cnt=0.
- Load extension, rdata=0x80FF7F01, wa=3:
  - lb at o=3 -> reg_wd=0xFFFFFF80.
  - lbu at o=3 -> 0x00000080.
  - lh at o=2 -> 0xFFFF80FF.
  - lhu at o=0 -> 0x00007F01.
  - Each produces one reg_we pulse, one cycle after capture.
- Misaligned: lw at alu=0x1002 with we=1 -> reg_we stays 0, wb_adel=1 for exactly one cycle.
  - lh at 0x1003 gives the same result.
- Stall: capture an ALU op (wa=5, alu=0x1234), then hold wb_stall=1 for 4 cycles -> exactly one reg_we pulse with reg_wd=0x00001234; mem_ready=0 throughout; the next instruction is accepted only after release.
- Flush: flush=1 while holding an ALU op and offering another -> no reg_we for either; wb_valid=0 next cycle.
  - Writing to wa=0 -> reg_we=0, retire_cnt increments by 1.
- Counter wrap (WB_RETIRE_CNT_EN): preload via 2^32-1 retirements (force) -> next retirement reads 0.
